mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: multiplexes an instruction-fetch port and a data port onto a single
// memory request channel. Data wins ties unless the fetch port has been passed over MAXD times
// in a row. Protocol violations and memory timeouts land in a sticky error state.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned MAXD    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [15:0] iAddr,
  output logic [15:0] iRdata,
  output logic        iDone,
  output logic        iStall,
  input  logic        dReq,
  input  logic        dWr,
  input  logic [15:0] dAddr,
  input  logic [15:0] dWdata,
  output logic [15:0] dRdata,
  output logic        dDone,
  output logic        dStall,
  output logic        mEn,
  output logic        mWr,
  output logic [15:0] mAddr,
  output logic [15:0] mWdata,
  input  logic        mBusy,
  input  logic        mDone,
  input  logic [15:0] mRdata,
  output logic        err
);

  localparam int unsigned CntW = ($clog2(MAXD + 1) < 2) ? 2 : $clog2(MAXD + 1);
  localparam int unsigned TmoW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAXD);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StIssueI, StIssueD, StWaitI, StWaitD, StErr} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] dcnt_q, dcnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  // Attributes of the owning request captured at grant, used to spot mid-access changes.
  logic [15:0]     own_addr_q, own_addr_d;
  logic            own_wr_q, own_wr_d;
  logic [15:0]     own_wdata_q, own_wdata_d;

  logic        in_i, in_d, in_wait, active;
  logic        own_req, own_wr, viol, stray, done_ok;
  logic [15:0] own_addr, own_wdata;

  // Decode the owning port and detect protocol violations in the current cycle.
  always_comb begin
    in_i      = (state_q == StIssueI) || (state_q == StWaitI);
    in_d      = (state_q == StIssueD) || (state_q == StWaitD);
    in_wait   = (state_q == StWaitI) || (state_q == StWaitD);
    active    = in_i || in_d;
    own_req   = in_i ? iReq  : dReq;
    own_addr  = in_i ? iAddr : dAddr;
    own_wr    = in_i ? 1'b0  : dWr;
    own_wdata = in_i ? 16'h0 : dWdata;
    viol      = active && (!own_req || (own_addr != own_addr_q) || (own_wr != own_wr_q) ||
                           (own_wdata != own_wdata_q));
    stray     = mDone && !in_wait;
    done_ok   = mDone && in_wait && !viol;
  end

  // Next-state logic: grant selection, issue handshake, wait/timeout and error capture.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    tmo_d       = tmo_q;
    own_addr_d  = own_addr_q;
    own_wr_d    = own_wr_q;
    own_wdata_d = own_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (mDone) begin
          state_d = StErr;
        end else if (dReq && !(iReq && (dcnt_q == MaxCnt))) begin
          state_d     = StIssueD;
          own_addr_d  = dAddr;
          own_wr_d    = dWr;
          own_wdata_d = dWdata;
          // Only count data grants that actually pass over a waiting fetch.
          if (!iReq) begin
            dcnt_d = '0;
          end else if (dcnt_q != MaxCnt) begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end else if (iReq) begin
          state_d     = StIssueI;
          own_addr_d  = iAddr;
          own_wr_d    = 1'b0;
          own_wdata_d = 16'h0;
          dcnt_d      = '0;
        end
      end
      StIssueI, StIssueD: begin
        if (viol || mDone) begin
          state_d = StErr;
        end else if (!mBusy) begin
          state_d = (state_q == StIssueI) ? StWaitI : StWaitD;
          tmo_d   = '0;
        end
      end
      StWaitI, StWaitD: begin
        if (viol) begin
          state_d = StErr;
        end else if (mDone) begin
          state_d = StIdle;
        end else if (tmo_q == TmoLast) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      dcnt_q      <= '0;
      tmo_q       <= '0;
      own_addr_q  <= '0;
      own_wr_q    <= 1'b0;
      own_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      tmo_q       <= tmo_d;
      own_addr_q  <= own_addr_d;
      own_wr_q    <= own_wr_d;
      own_wdata_q <= own_wdata_d;
    end
  end

  // Output decode: memory channel from the issuing port, done/rdata gated by a clean completion.
  always_comb begin
    mEn    = (state_q == StIssueI) || (state_q == StIssueD);
    mWr    = (state_q == StIssueD) ? dWr : 1'b0;
    mAddr  = (state_q == StIssueI) ? iAddr : ((state_q == StIssueD) ? dAddr : 16'h0);
    mWdata = (state_q == StIssueD) ? dWdata : 16'h0;
    iDone  = done_ok && (state_q == StWaitI);
    dDone  = done_ok && (state_q == StWaitD);
    iRdata = iDone ? mRdata : 16'h0;
    dRdata = dDone ? mRdata : 16'h0;
    iStall = iReq && !iDone;
    dStall = dReq && !dDone;
    err    = (state_q == StErr) || viol || stray;
  end

endmodule
